// File: rtl/synth_cmd_arbiter_if.sv
// Command-port bundle for synth_cmd_arbiter: two requester handshakes
// plus the byte/strobe stream toward the oscillator parameter decoder.
// master: requesters and the decoder side. slave: the arbiter.
interface synth_cmd_arbiter_if;
  logic        i_req0_valid;
  logic [7:0]  i_req0_cmd;
  logic [23:0] i_req0_data;
  logic        o_req0_ready;
  logic        i_req1_valid;
  logic [7:0]  i_req1_cmd;
  logic [23:0] i_req1_data;
  logic        o_req1_ready;
  logic [7:0]  o_data;
  logic        o_data_load;
  logic        o_busy;
  logic        o_grant;
  logic        o_err;

  modport master (
    output i_req0_valid, i_req0_cmd, i_req0_data,
    output i_req1_valid, i_req1_cmd, i_req1_data,
    input  o_req0_ready, o_req1_ready,
    input  o_data, o_data_load, o_busy, o_grant, o_err
  );

  modport slave (
    input  i_req0_valid, i_req0_cmd, i_req0_data,
    input  i_req1_valid, i_req1_cmd, i_req1_data,
    output o_req0_ready, o_req1_ready,
    output o_data, o_data_load, o_busy, o_grant, o_err
  );
endinterface

// File: rtl/synth_cmd_arbiter.sv
// synth_cmd_arbiter: shares the synth parameter command port between two
// requesters. Whole commands (opcode + payload) are accepted over
// valid/ready, arbitrated round-robin, and serialized as byte slots:
// opcode, payload bytes LSB first, then one flush byte.
// Build option: define SYNTH_ARB_FIXED_PRIO_EN for fixed priority
// (requester 0 wins every tie, no round-robin pointer).
//
// state  | meaning
// S_IDLE | waiting for a command; ready offered to the candidate requester
// S_SEND | streaming opcode/payload/flush slots, o_busy high
module synth_cmd_arbiter #(
  parameter int         STROBE_LOW  = 2,
  parameter int         STROBE_HIGH = 1,
  parameter logic [7:0] FLUSH_BYTE  = 8'h00
) (
  input logic               i_clk,
  input logic               i_rst,
  synth_cmd_arbiter_if.slave bus
);

  localparam int         SLOT      = STROBE_LOW + STROBE_HIGH;
  localparam logic [7:0] SLOT_LAST = 8'(SLOT - 1);
  localparam logic [7:0] HIGH_CYC  = 8'(STROBE_HIGH);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t      r_state;
  logic [7:0]  r_cyc;      // cycles left in the current slot, counts to 0
  logic [2:0]  r_slots;    // slots left after the current one
  logic [23:0] r_shift;    // captured payload, consumed LSB byte first
  logic [7:0]  r_data;
  logic        r_load;
  logic        r_busy;
  logic        r_grant;
  logic        r_err;
`ifndef SYNTH_ARB_FIXED_PRIO_EN
  logic        r_last;     // requester served last; the other wins a tie
`endif

  logic        w_pick;
  logic        w_rdy0;
  logic        w_rdy1;
  logic        w_acc;
  logic [7:0]  w_cmd;
  logic [23:0] w_dat;
  logic [1:0]  w_len;
  logic        w_ok;

  // Candidate selection and combinational ready, only offered in IDLE.
  always_comb begin
`ifdef SYNTH_ARB_FIXED_PRIO_EN
    w_pick = ~bus.i_req0_valid;
`else
    w_pick = (bus.i_req0_valid & bus.i_req1_valid) ? ~r_last : bus.i_req1_valid;
`endif
    w_rdy0 = (r_state == S_IDLE) & ~i_rst & bus.i_req0_valid & ~w_pick;
    w_rdy1 = (r_state == S_IDLE) & ~i_rst & bus.i_req1_valid & w_pick;
    w_acc  = w_rdy0 | w_rdy1;
    w_cmd  = w_pick ? bus.i_req1_cmd  : bus.i_req0_cmd;
    w_dat  = w_pick ? bus.i_req1_data : bus.i_req0_data;
  end

  // Opcode decode: payload byte count, invalid opcodes flagged.
  always_comb begin
    w_len = 2'd0;
    w_ok  = 1'b1;
    case (w_cmd)
      8'h01, 8'h11:               w_len = 2'd1;
      8'h02, 8'h12:               w_len = 2'd3;
      8'h03, 8'h04, 8'h13, 8'h14: w_len = 2'd2;
      default:                    w_ok  = 1'b0;
    endcase
  end

  // Arbitration FSM with slot timer and registered stream outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cyc   <= 8'd0;
      r_slots <= 3'd0;
      r_shift <= 24'd0;
      r_data  <= 8'd0;
      r_load  <= 1'b0;
      r_busy  <= 1'b0;
      r_grant <= 1'b0;
      r_err   <= 1'b0;
`ifndef SYNTH_ARB_FIXED_PRIO_EN
      r_last  <= 1'b1;
`endif
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_load <= 1'b0;
          if (w_acc) begin
            r_grant <= w_pick;
`ifndef SYNTH_ARB_FIXED_PRIO_EN
            r_last  <= w_pick;
`endif
            if (w_ok) begin
              r_state <= S_SEND;
              r_busy  <= 1'b1;
              r_data  <= w_cmd;
              r_shift <= w_dat;
              r_slots <= {1'b0, w_len} + 3'd1;
              r_cyc   <= SLOT_LAST;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (r_cyc == 8'd0) begin
            r_load <= 1'b0;
            if (r_slots == 3'd0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_slots <= r_slots - 3'd1;
              r_cyc   <= SLOT_LAST;
              if (r_slots == 3'd1) begin
                r_data <= FLUSH_BYTE;
              end else begin
                r_data  <= r_shift[7:0];
                r_shift <= {8'h00, r_shift[23:8]};
              end
            end
          end else begin
            r_cyc  <= r_cyc - 8'd1;
            r_load <= (r_cyc - 8'd1) < HIGH_CYC;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_req0_ready = w_rdy0;
  assign bus.o_req1_ready = w_rdy1;
  assign bus.o_data       = r_data;
  assign bus.o_data_load  = r_load;
  assign bus.o_busy       = r_busy;
  assign bus.o_grant      = r_grant;
  assign bus.o_err        = r_err;

endmodule

// File: tb/tb_synth_cmd_arbiter.sv
// Directed bench for synth_cmd_arbiter with default slot timing (3 cycles/slot).
module tb_synth_cmd_arbiter;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [7:0] got_b[$];
  int         got_c[$];
  int         busy_n;

`ifdef SYNTH_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  synth_cmd_arbiter_if bus();

  synth_cmd_arbiter dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer a command and wait (bounded) for ready, then let it be accepted.
  task automatic accept(input int r, input logic [7:0] c, input logic [23:0] d, input string tag);
    bit seen;
    seen = 1'b0;
    if (r == 0) begin
      bus.i_req0_valid = 1'b1; bus.i_req0_cmd = c; bus.i_req0_data = d;
    end else begin
      bus.i_req1_valid = 1'b1; bus.i_req1_cmd = c; bus.i_req1_data = d;
    end
    for (int i = 0; i < 50; i++) begin
      #1;
      if ((r == 0) ? bus.o_req0_ready : bus.o_req1_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_ready"}, 32'(seen), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (r == 0) bus.i_req0_valid = 1'b0;
    else        bus.i_req1_valid = 1'b0;
  endtask

  // Record load rising edges (byte, cycle index) until busy falls.
  task automatic collect();
    logic pl;
    pl = 1'b0;
    got_b.delete();
    got_c.delete();
    busy_n = 0;
    for (int k = 1; k <= 60; k++) begin
      if (bus.o_busy) busy_n++;
      if (bus.o_data_load && !pl) begin
        got_b.push_back(bus.o_data);
        got_c.push_back(k);
      end
      pl = bus.o_data_load;
      if (!bus.o_busy) break;
      @(negedge clk);
    end
  endtask

  // eb holds expected bytes, first slot in the top byte.
  task automatic check_trace(input string tag, input logic [39:0] eb, input int n, input int busy_exp);
    check({tag, "_nbytes"}, 32'(got_b.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_byte%0d", tag, i),
            (i < got_b.size()) ? 32'(got_b[i]) : 32'hxxxx_xxxx, 32'(eb[39-8*i -: 8]));
      check($sformatf("%s_cyc%0d", tag, i),
            (i < got_c.size()) ? 32'(got_c[i]) : 32'hxxxx_xxxx, 32'(3 * (i + 1)));
    end
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(busy_exp));
    check({tag, "_load_idle"}, 32'(bus.o_data_load), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.o_busy) begin
        idle = 1'b1;
        break;
      end
    end
    check({tag, "_idle"}, 32'(idle), 32'd1);
  endtask

  initial begin
    int   nr;
    logic prev;
    logic rg[4];
    int   rt[4];
    logic [7:0] ro[4];
    int   bad;

    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.i_req0_valid = 1'b0; bus.i_req0_cmd = 8'h00; bus.i_req0_data = 24'h0;
    bus.i_req1_valid = 1'b0; bus.i_req1_cmd = 8'h00; bus.i_req1_data = 24'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_data",  32'(bus.o_data), 32'h0);
    check("rst_load",  32'(bus.o_data_load), 32'h0);
    check("rst_busy",  32'(bus.o_busy), 32'h0);
    check("rst_grant", 32'(bus.o_grant), 32'h0);
    check("rst_err",   32'(bus.o_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Freq command from req0; inputs change while in flight.
    accept(0, 8'h02, 24'hABCDEF, "freq");
    bus.i_req0_cmd  = 8'h04;
    bus.i_req0_data = 24'h111111;
    check("freq_grant", 32'(bus.o_grant), 32'd0);
    check("freq_first", 32'(bus.o_data), 32'h02);
    collect();
    check_trace("freq", 40'h02EFCDAB00, 5, 15);

    // Phase command from req1.
    @(negedge clk);
    accept(1, 8'h13, 24'h001234, "phase");
    check("phase_grant", 32'(bus.o_grant), 32'd1);
    collect();
    check_trace("phase", 40'h1334120000, 4, 12);

    // Continuous tie between two wave commands.
    @(negedge clk);
    bus.i_req0_valid = 1'b1; bus.i_req0_cmd = 8'h01; bus.i_req0_data = 24'h0000AA;
    bus.i_req1_valid = 1'b1; bus.i_req1_cmd = 8'h11; bus.i_req1_data = 24'h000055;
    nr = 0;
    prev = 1'b0;
    for (int t = 0; t < 80 && nr < 4; t++) begin
      #1;
      if (bus.o_busy && !prev) begin
        rg[nr] = bus.o_grant;
        rt[nr] = t;
        ro[nr] = bus.o_data;
        nr++;
        if (nr == 4) begin
          bus.i_req0_valid = 1'b0;
          bus.i_req1_valid = 1'b0;
        end
      end
      prev = bus.o_busy;
      @(negedge clk);
    end
    check("tie_count", 32'(nr), 32'd4);
    if (nr == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("tie_grant%0d", i), 32'(rg[i]), FIXED ? 32'd0 : 32'(i % 2));
        check($sformatf("tie_op%0d", i), 32'(ro[i]),
              (FIXED || (i % 2 == 0)) ? 32'h01 : 32'h11);
        if (i > 0) check($sformatf("tie_gap%0d", i), 32'(rt[i] - rt[i-1]), 32'd10);
      end
    end
    wait_idle("tie");

    // Invalid opcode: ready pulse, error pulse, no stream activity.
    bus.i_req0_valid = 1'b1; bus.i_req0_cmd = 8'h07; bus.i_req0_data = 24'h000000;
    #1;
    check("inv_ready", 32'(bus.o_req0_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.i_req0_valid = 1'b0;
    check("inv_err",   32'(bus.o_err), 32'd1);
    check("inv_busy",  32'(bus.o_busy), 32'd0);
    check("inv_grant", 32'(bus.o_grant), 32'd0);
    @(negedge clk);
    check("inv_err_clr", 32'(bus.o_err), 32'd0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.o_data_load || bus.o_busy) bad++;
      @(negedge clk);
    end
    check("inv_quiet", 32'(bad), 32'd0);

    // Tie right after the dropped command: pointer advanced past req0.
    bus.i_req0_valid = 1'b1; bus.i_req0_cmd = 8'h01; bus.i_req0_data = 24'h0000AA;
    bus.i_req1_valid = 1'b1; bus.i_req1_cmd = 8'h11; bus.i_req1_data = 24'h000055;
    #1;
    check("rr_ready0", 32'(bus.o_req0_ready), FIXED ? 32'd1 : 32'd0);
    check("rr_ready1", 32'(bus.o_req1_ready), FIXED ? 32'd0 : 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.i_req0_valid = 1'b0;
    bus.i_req1_valid = 1'b0;
    check("rr_grant", 32'(bus.o_grant), FIXED ? 32'd0 : 32'd1);
    collect();
    check_trace("rr", FIXED ? 40'h01AA000000 : 40'h1155000000, 3, 9);

    // Async reset in the middle of a freq payload.
    @(negedge clk);
    accept(0, 8'h02, 24'h123456, "mid");
    repeat (3) @(negedge clk);
    check("mid_byte", 32'(bus.o_data), 32'h56);
    bus.i_req0_valid = 1'b1; bus.i_req0_cmd = 8'h01; bus.i_req0_data = 24'h0000C3;
    bus.i_req1_valid = 1'b1; bus.i_req1_cmd = 8'h12; bus.i_req1_data = 24'h777777;
    #2 rst = 1'b1;
    #1;
    check("arst_data",   32'(bus.o_data), 32'h0);
    check("arst_load",   32'(bus.o_data_load), 32'h0);
    check("arst_busy",   32'(bus.o_busy), 32'h0);
    check("arst_ready0", 32'(bus.o_req0_ready), 32'h0);
    check("arst_ready1", 32'(bus.o_req1_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_ready0", 32'(bus.o_req0_ready), 32'd1);
    check("post_ready1", 32'(bus.o_req1_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.i_req0_valid = 1'b0;
    bus.i_req1_valid = 1'b0;
    check("post_grant", 32'(bus.o_grant), 32'd0);
    collect();
    check_trace("post", 40'h01C3000000, 3, 9);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/synth_cmd_arbiter.md
Name: synth_cmd_arbiter

Overview:
- Shares the synth parameter command port between two requesters, e.g. a host/UART parser and a sequencer.
- Accepts whole commands (opcode + 24-bit payload) per requester over a valid/ready handshake and arbitrates round-robin.
- Serializes the winning command into the byte/strobe stream the oscillator parameter decoder consumes: opcode, payload bytes LSB first, then one flush byte.
- A command is never interleaved with another.

Parameters:
- STROBE_LOW, 2, cycles o_data_load is held low per byte slot with o_data stable (setup); minimum 1.
- STROBE_HIGH, 1, cycles o_data_load is held high per byte slot; minimum 1.
- FLUSH_BYTE, 8'h00, value driven on the trailing flush slot.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_req0_valid  input  1  requester 0 has a command.
- i_req0_cmd  input  8  requester 0 opcode.
- i_req0_data  input  24  requester 0 payload, right-aligned.
- o_req0_ready  output  1  requester 0 command accepted when high with valid.
- i_req1_valid, i_req1_cmd, i_req1_data, o_req1_ready  as requester 0.
- o_data  output  8  byte to decoder.
- o_data_load  output  1  byte strobe; the decoder samples on its rising edge.
- o_busy  output  1  command in flight.
- o_grant  output  1  requester index of the current/last command.
- o_err  output  1  one-cycle pulse: unknown opcode accepted and dropped.

Behaviour:
- Reset (async, any state, including mid-command): o_data=0, o_data_load=0, o_busy=0, o_grant=0, o_err=0, readies 0, FSM to IDLE, RR pointer so requester 0 wins the first tie.
  - A strobe cut short by reset is acceptable. Downstream resync is the system's job.
- Opcode payload byte counts N:
  - 01/11 (wave): 1 byte = data[7:0].
  - 02/12 (freq): 3 bytes = data[7:0], [15:8], [23:16].
  - 03/04/13/14 (phase/amp): 2 bytes = data[7:0], [15:8].
  - Any other opcode: invalid.
- Each command emits 1 opcode slot + N payload slots + 1 flush slot = N+2 slots.
- Slot timing: o_data updates at slot start. Load is low for STROBE_LOW cycles, then high for STROBE_HIGH cycles. o_data is stable for the whole slot.
  - Defaults give 3 cycles/slot: wave 9, freq 15, phase/amp 12 cycles.
- FSM states:
  - IDLE: o_reqN_ready is combinational, high only for the granted candidate.
    - Candidate = sole valid requester; if both are valid, the one not served last.
    - On valid&ready edge: capture cmd/data and set o_grant.
    - Valid opcode → SEND with o_busy=1.
    - Invalid opcode → pulse o_err next cycle, stay IDLE, RR pointer still advances.
  - SEND: load slot counter and byte index; step through slots. After the last cycle of the flush slot → IDLE.
    - o_busy drops the same edge. o_data_load is low in IDLE.
- Back-to-back: earliest next acceptance is the first IDLE cycle. Minimum one IDLE cycle between commands; load stays low across it.
- Requester inputs are only sampled at acceptance; later changes do not affect an in-flight command.
- Valid deasserted while not ready: no transfer, no error. Requesters are expected to hold valid until ready.

Optional Feature:
- SYNTH_ARB_FIXED_PRIO_EN
  - Defined: fixed priority; requester 0 always wins a tie; RR pointer removed.
  - Undefined: round-robin as above.

Test Plan:
- Reset, then req0 cmd 8'h02 data 24'hABCDEF → o_data slots 02, EF, CD, AB, 00. o_data_load high in cycles 3,6,9,12,15 after acceptance (defaults). o_busy high for 15 cycles.
- req1 cmd 8'h13 data 24'h001234 → slots 13, 34, 12, 00. o_grant=1. 12 cycles.
- Both valid simultaneously with wave 01/AA and 11/55, held continuously → req0 served first, req1 next (one IDLE gap); further ties alternate. With SYNTH_ARB_FIXED_PRIO_EN: req0 wins every tie.
- req0 cmd 8'h07 → o_req0_ready pulse, o_err one cycle, no o_data_load edges, o_busy stays 0.
- i_rst asserted mid-freq payload → outputs zero immediately (async). Next command after release starts with an opcode slot.
- req0 changes cmd/data while busy → emitted bytes match the values captured at acceptance.
